// File: rtl/phase_delay_ctrl_pkg.sv
// phase_delay_ctrl_pkg: shared definitions for the phase-delay controller and the delay datapath wrapper
//   DEF_WAIT_CNT_SIZE - default width of waitCnt (matches the delay datapath)
//   DEF_PHASE_BITS    - default width of the phase command
//   state_t           - controller state encoding
package phase_delay_ctrl_pkg;
    localparam int DEF_WAIT_CNT_SIZE = 11;
    localparam int DEF_PHASE_BITS = 8;
    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        MEASURE    = 2'd1,
        CALC       = 2'd2,
        ARM        = 2'd3
    } state_t;
endpackage

// File: rtl/phase_delay_ctrl_mult.sv
// seq_mult: sequential shift-add multiplier, A_W x B_W, B_W-cycle latency
//   clk, rst   - clock, synchronous active-high reset
//   start      - load operands a, b and begin (ignored bits of a previous run are discarded)
//   busy       - multiply in progress
//   done       - one-cycle pulse when prod is valid
//   prod       - a*b, held until the next start
module seq_mult #(
    parameter int A_W = 12,
    parameter int B_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic               busy,
    output logic               done,
    output logic [A_W+B_W-1:0] prod
);
    localparam int CW = $clog2(B_W + 1);
    logic [A_W+B_W-1:0] mcand;
    logic [B_W-1:0] mplier;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            prod <= '0;
            mcand <= '0;
            mplier <= '0;
            cnt <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                prod <= '0;
                mcand <= {{B_W{1'b0}}, a};
                mplier <= b;
                cnt <= CW'(B_W);
                busy <= 1'b1;
            end else if (busy) begin
                prod <= prod + (mplier[0] ? mcand : '0);
                mcand <= mcand << 1;
                mplier <= mplier >> 1;
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/phase_delay_ctrl.sv
// phase_delay_ctrl: measures the sigIn period and converts a phase command into a clamped waitCnt
//   clk, rst   - clock, synchronous active-high reset
//   sigIn      - asynchronous reference signal
//   phaseCmd   - phase fraction phaseCmd/2^PHASE_BITS of one period, sampled at each calculation start
//   waitCnt    - delay in clk cycles for the delay datapath, changed only on a sigIn rising edge
//   period     - last measured sigIn period in clk cycles
//   updStrobe  - one-cycle pulse when waitCnt is updated
//   clamped    - last applied waitCnt was limited to just below half a period
//   noSig      - no rising edge seen for 2^PER_SIZE-1 cycles
module phase_delay_ctrl import phase_delay_ctrl_pkg::*; #(
    parameter int WAIT_CNT_SIZE = DEF_WAIT_CNT_SIZE,
    parameter int PHASE_BITS = DEF_PHASE_BITS,
    parameter int PER_SIZE = WAIT_CNT_SIZE + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sigIn,
    input  logic [PHASE_BITS-1:0]    phaseCmd,
    output logic [WAIT_CNT_SIZE-1:0] waitCnt,
    output logic [PER_SIZE-1:0]      period,
    output logic                     updStrobe,
    output logic                     clamped,
    output logic                     noSig
);
    localparam logic [PER_SIZE-1:0] MAX_WAIT = PER_SIZE'((1 << WAIT_CNT_SIZE) - 1);
    state_t state, nextState;
    logic s1, s2, s3, rise, perSat, lost, multStart, apply;
    logic multBusy, multDone;
    logic [PER_SIZE+PHASE_BITS-1:0] multProd;
    logic [PER_SIZE-1:0] perCnt, calcPer, raw, limitFull, limit;
    logic [WAIT_CNT_SIZE-1:0] pending;
    logic pendClamp;
    assign rise = s2 & ~s3;
    assign perSat = &perCnt;
    // the clamp uses the period the multiply was started with, not one captured during CALC
    assign raw = PER_SIZE'(multProd >> PHASE_BITS);
    assign limitFull = (calcPer < PER_SIZE'(2)) ? '0 : (calcPer >> 1) - PER_SIZE'(1);
    assign limit = (limitFull > MAX_WAIT) ? MAX_WAIT : limitFull;
    seq_mult #(.A_W(PER_SIZE), .B_W(PHASE_BITS)) mult (
        .clk(clk),
        .rst(rst),
        .start(multStart),
        .a(perCnt),
        .b(phaseCmd),
        .busy(multBusy),
        .done(multDone),
        .prod(multProd)
    );
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_FIRST;
        else state <= nextState;
    end
    always_comb begin
        nextState = state;
        multStart = 1'b0;
        apply = 1'b0;
        lost = (state != WAIT_FIRST) && perSat && !rise;
        case (state)
            WAIT_FIRST: nextState = rise ? MEASURE : WAIT_FIRST;
            MEASURE: begin
                multStart = rise;
                nextState = rise ? CALC : MEASURE;
            end
            CALC: nextState = (multDone && !multBusy) ? ARM : CALC;
            ARM: begin
                apply = rise;
                multStart = rise;
                nextState = rise ? CALC : ARM;
            end
            default: nextState = WAIT_FIRST;
        endcase
        if (lost) begin
            nextState = WAIT_FIRST;
            multStart = 1'b0;
            apply = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
            perCnt <= '0;
            calcPer <= '0;
            pending <= '0;
            pendClamp <= 1'b0;
            waitCnt <= '0;
            period <= '0;
            updStrobe <= 1'b0;
            clamped <= 1'b0;
            noSig <= 1'b0;
        end else begin
            s1 <= sigIn;
            s2 <= s1;
            s3 <= s2;
            updStrobe <= apply;
            perCnt <= (state == WAIT_FIRST) ? (rise ? PER_SIZE'(1) : '0)
                    : rise ? PER_SIZE'(1) : perSat ? perCnt : perCnt + PER_SIZE'(1);
            if (state != WAIT_FIRST && rise) period <= perCnt;
            if (multStart) calcPer <= perCnt;
            if (state == CALC && multDone) begin
                pending <= (raw > limit) ? WAIT_CNT_SIZE'(limit) : WAIT_CNT_SIZE'(raw);
                pendClamp <= raw > limit;
            end
            if (apply) begin
                waitCnt <= pending;
                clamped <= pendClamp;
            end
            if (state == WAIT_FIRST && rise) noSig <= 1'b0;
            if (lost) begin
                noSig <= 1'b1;
                waitCnt <= '0;
                clamped <= 1'b0;
                period <= '0;
            end
        end
    end
endmodule

// File: tb/tb_phase_delay_ctrl.sv
// tb_phase_delay_ctrl: directed sigIn waveforms with a scoreboard of expected waitCnt updates
module tb_phase_delay_ctrl;
    typedef struct packed {
        logic [10:0] w;
        logic        c;
        logic [11:0] p;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sigIn = 1'b0;
    logic [7:0] phaseCmd = '0;
    logic [10:0] waitCnt;
    logic [11:0] period;
    logic updStrobe, clamped, noSig;
    int nChecks = 0;
    int nFail = 0;
    int cycNum = 0;
    int lastStrobeCyc = 0;
    exp_t sbq[$];
    exp_t got;
    phase_delay_ctrl dut (
        .clk(clk),
        .rst(rst),
        .sigIn(sigIn),
        .phaseCmd(phaseCmd),
        .waitCnt(waitCnt),
        .period(period),
        .updStrobe(updStrobe),
        .clamped(clamped),
        .noSig(noSig)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cycNum <= cycNum + 1;
    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act != exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask
    task automatic push(input int w, input int c, input int p);
        exp_t e;
        e.w = 11'(w);
        e.c = 1'(c);
        e.p = 12'(p);
        sbq.push_back(e);
    endtask
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic wave(input int p, input int n);
        for (int i = 0; i < n; i++) begin
            sigIn = 1'b1;
            cyc(p / 2);
            sigIn = 1'b0;
            cyc(p - p / 2);
        end
    endtask
    always @(negedge clk) begin
        if (updStrobe) begin
            if (sbq.size() == 0) begin
                nChecks++;
                nFail++;
                $display("FAIL unexpected updStrobe: waitCnt=%0d clamped=%0d period=%0d", waitCnt, clamped, period);
            end else begin
                got = sbq.pop_front();
                chk("strobe waitCnt", int'(waitCnt), int'(got.w));
                chk("strobe clamped", int'(clamped), int'(got.c));
                chk("strobe period", int'(period), int'(got.p));
            end
            lastStrobeCyc = cycNum;
        end
    end
    initial begin
        cyc(3);
        rst = 1'b0;
        chk("reset waitCnt", int'(waitCnt), 0);
        chk("reset period", int'(period), 0);
        chk("reset updStrobe", int'(updStrobe), 0);
        chk("reset clamped", int'(clamped), 0);
        chk("reset noSig", int'(noSig), 0);
        // lock at period 100, phase 64/256 -> 25
        phaseCmd = 8'd64;
        repeat (4) push(25, 0, 100);
        wave(100, 6);
        // phase 200/256 -> raw 78, clamped to 49; applied one rise late
        phaseCmd = 8'd200;
        push(25, 0, 100);
        push(49, 1, 100);
        push(49, 1, 100);
        wave(100, 3);
        // phase 128/256 at 100 then 60 -> 49 and 29, both clamped
        phaseCmd = 8'd128;
        repeat (4) push(49, 1, 100);
        push(49, 1, 60);
        push(29, 1, 60);
        wave(100, 3);
        wave(60, 3);
        // loss of signal
        for (int i = 0; i < 5000 && !noSig; i++) @(negedge clk);
        chk("los noSig", int'(noSig), 1);
        chk("los delay", cycNum - lastStrobeCyc, 4095);
        chk("los waitCnt", int'(waitCnt), 0);
        chk("los period", int'(period), 0);
        chk("los clamped", int'(clamped), 0);
        @(posedge clk);
        #1;
        wave(100, 1);
        chk("relock noSig", int'(noSig), 0);
        chk("relock waitCnt", int'(waitCnt), 0);
        push(49, 1, 100);
        push(49, 1, 100);
        wave(100, 3);
        // reset a few cycles into CALC
        push(49, 1, 100);
        sigIn = 1'b1;
        cyc(5);
        sigIn = 1'b0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midcalc rst waitCnt", int'(waitCnt), 0);
        chk("midcalc rst period", int'(period), 0);
        chk("midcalc rst updStrobe", int'(updStrobe), 0);
        chk("midcalc rst clamped", int'(clamped), 0);
        chk("midcalc rst noSig", int'(noSig), 0);
        cyc(50);
        push(49, 1, 100);
        wave(100, 3);
        // period 200, phaseCmd 32 then 96 mid-period
        phaseCmd = 8'd32;
        push(49, 1, 100);
        push(12, 0, 200);
        push(25, 0, 200);
        wave(200, 3);
        push(25, 0, 200);
        sigIn = 1'b1;
        cyc(100);
        phaseCmd = 8'd96;
        sigIn = 1'b0;
        cyc(100);
        chk("hold waitCnt", int'(waitCnt), 25);
        push(25, 0, 200);
        push(75, 0, 200);
        wave(200, 2);
        cyc(20);
        chk("scoreboard drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
